image_blitter: RTL and testbench
================================

# image_blitter

Parametrised ROM-to-framebuffer blitter that draws a rectangular IMG_W x IMG_H image at a runtime origin (x0, y0) on the VGA framebuffer. It scans the image in row-major order, reads an external synchronous image ROM with configurable latency, and emits pixel writes (x_out, y_out, colour_out, writeEn) aligned to the ROM data. It adds screen clipping, horizontal mirroring and a busy/done handshake, and serves backgrounds, sprites and trailer frames from one engine.

## Interface
Parameters:
- IMG_W, 320, image width in pixels (≥1)
- IMG_H, 240, image height in pixels (≥1)
- SCREEN_W, 320, visible width; writes with x ≥ SCREEN_W are suppressed
- SCREEN_H, 240, visible height; writes with y ≥ SCREEN_H are suppressed
- XW, 9, x coordinate width
- YW, 8, y coordinate width
- CW, 3, colour width
- AW, 17, ROM address width (≥ clog2(IMG_W*IMG_H))
- ROM_LAT, 1, ROM read latency in cycles (1..4)
- KEY, 0, transparent colour value (used only with BLIT_COLOUR_KEY_EN)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to draw; sampled only in IDLE
- x0  in  XW  screen x of image column 0; latched on accepted start
- y0  in  YW  screen y of image row 0; latched on accepted start
- hflip  in  1  horizontal mirror; latched on accepted start
- rom_addr  out  AW  image ROM read address
- rom_data  in  CW  ROM data, valid ROM_LAT cycles after rom_addr
- x_out  out  XW  pixel x
- y_out  out  YW  pixel y
- colour_out  out  CW  pixel colour (driven from rom_data)
- writeEn  out  1  framebuffer write strobe
- busy  out  1  high from the cycle after an accepted start through the last pipeline cycle
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, SCAN, DRAIN. IDLE→SCAN on start. SCAN→DRAIN after the address for pixel (IMG_W-1, IMG_H-1) is issued. DRAIN→IDLE after ROM_LAT cycles; done pulses for exactly one cycle on the IDLE-entry cycle.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1). col wraps to 0 and row increments at end of line.
- Address is computed without a multiplier: row_base += IMG_W per line. rom_addr = row_base + col, or row_base + (IMG_W-1-col) when hflip.
- Screen coordinates: sx = x0 + col, sy = y0 + row, each computed one bit wider. A pixel is visible if sx < SCREEN_W and sy < SCREEN_H with no carry-out. Invisible pixels are still read, but writeEn stays low for them.
- x, y and visible are delayed through a ROM_LAT-deep shift register so that x_out, y_out, writeEn and colour_out refer to the same pixel.
- colour_out is combinationally equal to rom_data. It is meaningful only while writeEn is high.
- start during SCAN/DRAIN is ignored. x0, y0 and hflip changes after acceptance have no effect.
- Reset, including mid-operation: on the next edge go to IDLE and clear the counters and the delay pipe. rom_addr, x_out, y_out, writeEn, busy and done all become 0. No writes follow a reset.

## Timing
- start sampled high at edge N:
  - SCAN is entered and the address for pixel 0 is driven during cycle N+1.
  - busy is high from cycle N+1.
- One address per cycle, with no stalls. SCAN lasts IMG_W*IMG_H cycles.
- writeEn for pixel k is asserted in cycle N+1+k+ROM_LAT.
- The last write occurs in cycle N+IMG_W*IMG_H+ROM_LAT. done is high and busy is low in the following cycle.
- Total start-to-done: IMG_W*IMG_H+ROM_LAT+1 cycles. A new start is accepted in the done cycle.

## Configuration
- BLIT_COLOUR_KEY_EN defined: writeEn is additionally gated by rom_data != KEY, so KEY-coloured pixels are transparent (sprite mode). Cycle timing and done are unchanged.
- BLIT_COLOUR_KEY_EN undefined: every visible pixel is written, and the KEY parameter is ignored.

## Test plan
- IMG_W=4, IMG_H=2, ROM_LAT=1, x0=10, y0=20, start at edge 0:
  - rom_addr sequence 0..7 in cycles 1..8.
  - writes (10,20)..(13,20) then (10,21)..(13,21) in cycles 2..9.
  - done in cycle 10.
- Same setup with hflip=1 -> rom_addr sequence 3,2,1,0,7,6,5,4, with x_out still 10..13 per row.
- x0=318, y0=239, 4x2 image -> only (318,239) and (319,239) are written; the other 6 pixels have writeEn=0; done timing is unchanged.
- ROM_LAT=3 -> writeEn/x_out lag rom_addr by exactly 3 cycles; done at start+12; start pulsed mid-scan is ignored.
- BLIT_COLOUR_KEY_EN, KEY=0, ROM words {0,5,0,7,...} -> writeEn is low for words equal to 0; non-zero pixels are written at their correct x.
- resetn=0 at the 3rd SCAN cycle -> next cycle is IDLE with all outputs 0 and no further writeEn. A new start then draws from pixel 0.

Source files
------------

// File: rtl/image_blitter.sv
// image_blitter: ROM-to-framebuffer rectangle blitter with clipping, mirroring and optional colour key (BLIT_COLOUR_KEY_EN)
module image_blitter #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int CW       = 3,
    parameter int AW       = 17,
    parameter int ROM_LAT  = 1,
    parameter int KEY      = 0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic          hflip,
    output logic [AW-1:0] rom_addr,
    input  logic [CW-1:0] rom_data,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [CW-1:0] colour_out,
    output logic          writeEn,
    output logic          busy,
    output logic          done
);
    localparam int CLW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int RLW = IMG_H > 1 ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [CLW-1:0]       col_q, col_d;
    logic [RLW-1:0]       row_q, row_d;
    logic [AW-1:0]        base_q, base_d;
    logic [1:0]           dcnt_q, dcnt_d;
    logic                 done_q, done_d;
    logic [XW-1:0]        x0_q;
    logic [YW-1:0]        y0_q;
    logic                 hflip_q;
    logic [XW:0]          sx;
    logic [YW:0]          sy;
    logic                 vis;
    logic [ROM_LAT-1:0][XW-1:0] xp_q;
    logic [ROM_LAT-1:0][YW-1:0] yp_q;
    logic [ROM_LAT-1:0]         vp_q;

    // One bit wider than the screen coordinate so an overflowing sum is caught as invisible
    assign sx  = {1'b0, x0_q} + (XW+1)'(col_q);
    assign sy  = {1'b0, y0_q} + (YW+1)'(row_q);
    assign vis = state_q == SCAN && !sx[XW] && !sy[YW] &&
                 sx < (XW+1)'(SCREEN_W) && sy < (YW+1)'(SCREEN_H);

    assign rom_addr   = state_q == SCAN ?
                        base_q + (hflip_q ? AW'(IMG_W-1) - AW'(col_q) : AW'(col_q)) : '0;
    assign x_out      = xp_q[ROM_LAT-1];
    assign y_out      = yp_q[ROM_LAT-1];
    assign colour_out = rom_data;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
`ifdef BLIT_COLOUR_KEY_EN
    assign writeEn    = vp_q[ROM_LAT-1] && rom_data != CW'(KEY);
`else
    assign writeEn    = vp_q[ROM_LAT-1];
`endif

    // State, scan counters and the origin/mirror latched on an accepted start
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            hflip_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
            if (state_q == IDLE && start) begin
                x0_q    <= x0;
                y0_q    <= y0;
                hflip_q <= hflip;
            end
        end
    end

    // Next state: raster scan with a running row base instead of a multiply, then wait out the ROM latency
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        dcnt_d  = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: state_d = start ? SCAN : IDLE;
            SCAN: begin
                if (col_q == CLW'(IMG_W-1)) begin
                    col_d = '0;
                    if (row_q == RLW'(IMG_H-1)) begin
                        row_d   = '0;
                        base_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        row_d  = row_q + 1'b1;
                        base_d = base_q + AW'(IMG_W);
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == 2'(ROM_LAT-1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Coordinate/visibility delay line keeping each write aligned with its ROM word
    always_ff @(posedge clk) begin
        if (!resetn) begin
            xp_q <= '0;
            yp_q <= '0;
            vp_q <= '0;
        end else begin
            xp_q[0] <= sx[XW-1:0];
            yp_q[0] <= sy[YW-1:0];
            vp_q[0] <= vis;
            for (int i = 1; i < ROM_LAT; i++) begin
                xp_q[i] <= xp_q[i-1];
                yp_q[i] <= yp_q[i-1];
                vp_q[i] <= vp_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_image_blitter.sv
// tb_image_blitter: table-driven and scoreboard bench for image_blitter on a 4x2 image
module tb_image_blitter;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  x0 = '0;
    logic [7:0]  y0 = '0;
    logic        hflip = 1'b0;
    logic [16:0] rom_addr;
    logic [2:0]  rom_data;
    logic [8:0]  x_out;
    logic [7:0]  y_out;
    logic [2:0]  colour_out;
    logic        writeEn, busy, done;

    image_blitter #(.IMG_W(4), .IMG_H(2), .ROM_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .x0(x0), .y0(y0), .hflip(hflip),
        .rom_addr(rom_addr), .rom_data(rom_data), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .writeEn(writeEn), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] rom [8];
    logic [2:0] rp [LAT];
    always @(posedge clk) begin
        rp[0] <= rom[rom_addr[2:0]];
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign rom_data = rp[LAT-1];

    typedef struct { int cyc; int x; int y; int c; } exp_t;
    typedef struct { int x0; int y0; int hf; int mid; int nw; int nk; int a0; } vec_t;

    exp_t exp_q[$];
    int n = 0, err = 0, nwr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (writeEn) begin
            exp_t e;
            nwr++;
            if (exp_q.size() == 0) begin
                n++;
                err++;
                $display("FAIL unexpected_write: got write at (%0d,%0d) cycle %0d expected none", x_out, y_out, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_x", int'(x_out), e.x);
                chk("wr_y", int'(y_out), e.y);
                chk("wr_colour", int'(colour_out), e.c);
            end
        end
    end

    task automatic run(input vec_t v);
        int s, a, c, r, sx, sy, got, pb;
        bit vis;
        @(negedge clk);
        x0 = 9'(v.x0); y0 = 8'(v.y0); hflip = v.hf[0]; start = 1'b1;
        @(posedge clk); #1;
        s = cyc; start = 1'b0; x0 = '1; y0 = '1; hflip = ~v.hf[0];
        nwr = 0;
        for (int k = 0; k < 8; k++) begin
            c = k % 4; r = k / 4;
            a = r * 4 + (v.hf != 0 ? 3 - c : c);
            sx = v.x0 + c; sy = v.y0 + r;
            vis = sx < 320 && sy < 240;
`ifdef BLIT_COLOUR_KEY_EN
            if (rom[a] == 3'd0) vis = 1'b0;
`endif
            if (vis) exp_q.push_back('{s + k + LAT, sx, sy, int'(rom[a])});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            c = k % 4; r = k / 4;
            if (k == 0) begin
                chk("first_addr", int'(rom_addr), v.a0);
                chk("busy_start", int'(busy), 1);
            end else begin
                chk("rom_addr", int'(rom_addr), r * 4 + (v.hf != 0 ? 3 - c : c));
            end
            if (v.mid != 0 && k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
        end
        got = -1; pb = int'(busy);
        for (int i = 0; i < 30 && got < 0; i++) begin
            @(negedge clk);
            if (done) begin
                got = cyc;
                chk("busy_at_done", int'(busy), 0);
                chk("busy_before_done", pb, 1);
            end
            pb = int'(busy);
        end
        chk("done_cycle", got, s + 8 + LAT);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
`ifdef BLIT_COLOUR_KEY_EN
        chk("write_count", nwr, v.nk);
`else
        chk("write_count", nwr, v.nw);
`endif
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t tbl[8];

    initial begin
        int s;
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int s;
        rom[0] = 3'd0; rom[1] = 3'd5; rom[2] = 3'd0; rom[3] = 3'd7;
        rom[4] = 3'd1; rom[5] = 3'd2; rom[6] = 3'd3; rom[7] = 3'd4;
        tbl[0] = '{10, 20, 0, 0, 8, 6, 0};
        tbl[1] = '{10, 20, 1, 0, 8, 6, 3};
        tbl[2] = '{318, 239, 0, 0, 2, 1, 0};
        tbl[3] = '{318, 239, 1, 1, 2, 1, 3};
        tbl[4] = '{319, 238, 0, 0, 2, 1, 0};
        tbl[5] = '{511, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 255, 1, 0, 0, 0, 3};
        tbl[7] = '{0, 0, 1, 1, 8, 6, 3};

        repeat (3) @(negedge clk);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_we", int'(writeEn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run(tbl[i]);

        @(negedge clk);
        x0 = 9'd10; y0 = 8'd20; hflip = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        s = cyc; start = 1'b0;
        nwr = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_cycle", cyc, s + 3);
        chk("mid_rst_addr", int'(rom_addr), 0);
        chk("mid_rst_we", int'(writeEn), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_x", int'(x_out), 0);
        chk("mid_rst_y", int'(y_out), 0);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_writes", nwr, 0);
        chk("post_rst_busy", int'(busy), 0);

        run(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n, err);
        $finish;
    end
endmodule
